// File: rtl/pipelined_bit_population_counter.sv
`timescale 1ns/1ps
// Pipelined population counter with a per-beat ones/zeros mode and a
// per-packet saturating accumulator.
//   stage 1: mode applied, per-chunk popcounts registered
//   stage 2: chunk counts summed into data_o
//   stage 3: running packet sum, reported on the eop beat
module pipelined_bit_population_counter #(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     srst_n_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     data_val_i,
  input  logic                     data_mode_i,
  input  logic                     data_eop_i,
  output logic [$clog2(WIDTH):0]   data_o,
  output logic                     data_val_o,
  output logic [ACC_WIDTH-1:0]     acc_o,
  output logic                     acc_val_o,
  output logic                     acc_ovf_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(CHUNK) + 1;
  localparam int OW     = $clog2(WIDTH) + 1;
  // Sum width is one bit wider than the larger operand so overflow is visible.
  localparam int SW     = ((ACC_WIDTH > OW) ? ACC_WIDTH : OW) + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  // Popcount of one chunk.
  function automatic logic [CW-1:0] popcount_chunk(input logic [CHUNK-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int b = 0; b < CHUNK; b++) begin
      c = c + CW'(v[b]);
    end
    return c;
  endfunction

  // ---------------- stage 1 ----------------
  logic [WIDTH-1:0]            word;
  logic [NCHUNK-1:0][CW-1:0]   chunk_cnt_next;
  logic [NCHUNK-1:0][CW-1:0]   chunk_cnt_reg;
  logic                        s1_val_reg;
  logic                        s1_eop_reg;

  // Zeros are counted as ones of the inverted word.
  assign word = data_mode_i ? ~data_i : data_i;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign chunk_cnt_next[gi] = popcount_chunk(word[gi*CHUNK +: CHUNK]);
    end
  endgenerate

  // Register per-chunk counts with their valid/eop qualifiers.
  always_ff @(posedge clk) begin
    if (!srst_n_i) begin
      chunk_cnt_reg <= '0;
      s1_val_reg    <= 1'b0;
      s1_eop_reg    <= 1'b0;
    end else begin
      s1_val_reg <= data_val_i;
      s1_eop_reg <= data_val_i & data_eop_i;
      if (data_val_i) begin
        chunk_cnt_reg <= chunk_cnt_next;
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [OW-1:0] beat_sum;
  logic          s2_eop_reg;

  // Adder tree over the registered chunk counts.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      beat_sum = beat_sum + OW'(chunk_cnt_reg[i]);
    end
  end

  // Register the beat count; data_o holds when no beat is present.
  always_ff @(posedge clk) begin
    if (!srst_n_i) begin
      data_o     <= '0;
      data_val_o <= 1'b0;
      s2_eop_reg <= 1'b0;
    end else begin
      data_val_o <= s1_val_reg;
      s2_eop_reg <= s1_val_reg & s1_eop_reg;
      if (s1_val_reg) begin
        data_o <= beat_sum;
      end
    end
  end

  // ---------------- stage 3 ----------------
  logic [ACC_WIDTH-1:0] run_reg;
  logic                 ovf_reg;
  logic [SW-1:0]        acc_sum;
  logic                 acc_over;
  logic [ACC_WIDTH-1:0] acc_sat;

  // Running sum plus this beat, clamped to the accumulator range.
  always_comb begin
    acc_sum  = SW'(run_reg) + SW'(data_o);
    acc_over = (acc_sum > SW'(ACC_MAX));
    acc_sat  = acc_over ? ACC_MAX : acc_sum[ACC_WIDTH-1:0];
  end

  // Accumulate each beat; on eop publish the total and restart from zero.
  always_ff @(posedge clk) begin
    if (!srst_n_i) begin
      run_reg   <= '0;
      ovf_reg   <= 1'b0;
      acc_o     <= '0;
      acc_val_o <= 1'b0;
      acc_ovf_o <= 1'b0;
    end else begin
      acc_val_o <= 1'b0;
      if (data_val_o) begin
        if (s2_eop_reg) begin
          acc_o     <= acc_sat;
          acc_ovf_o <= ovf_reg | acc_over;
          acc_val_o <= 1'b1;
          run_reg   <= '0;
          ovf_reg   <= 1'b0;
        end else begin
          run_reg <= acc_sat;
          ovf_reg <= ovf_reg | acc_over;
        end
      end
    end
  end

endmodule
